tick_scheduler: RTL
===================

// Module: tick_scheduler
// PURPOSE
//  Time-shares one external pulse_generator among NREQ requesters. Each requester
//  asks for a burst of `count` pulses spaced `ticks` clocks apart. The block
//  arbitrates round-robin, loads the winner's period into the generator, and counts
//  the generator's pulses. It forwards them as tick_out and signals done to the winner.
//  Sits between the etch-a-sketch control logic (cursor step/refresh timers) and the
//  shared pulse_generator instance.
// PARAMETERS
//  NREQ  4  number of requesters (>=2)
//  N     8  width of period (ticks); must match the pulse_generator N
//  C     8  width of per-request pulse count
// PORTS
//  clk        in   1        single clock, all logic on posedge
//  rst        in   1        asynchronous, active-low reset
//  req        in   NREQ     level request per requester; hold until done or abort
//  req_ticks  in   NREQ*N   packed periods, requester i at [i*N +: N]
//  req_count  in   NREQ*C   packed burst lengths, requester i at [i*C +: C]
//  grant      out  NREQ     one-hot owner, 0 when idle
//  done       out  NREQ     one-cycle pulse on owner's bit when its burst completes
//  busy       out  1        high in LOAD/RUN/DONE
//  tick_out   out  1        pulse_out forwarded while RUN, else 0
//  pg_rst     out  1        drives the generator's rst (active-high)
//  pg_ena     out  1        drives the generator's ena
//  pg_ticks   out  N        drives the generator's ticks; held stable during RUN
//  pg_out     in   1        the generator's out
// BEHAVIOUR
//  Reset (async, rst=0): state=IDLE, rr pointer=0, grant=0, done=0, busy=0,
//   tick_out=0, pg_ena=0, pg_rst=1, pg_ticks=0, internal latches=0.
//  States: IDLE -> LOAD -> RUN -> DONE -> IDLE.
//  IDLE: pg_rst=1, pg_ena=0. If any req is high, pick the first set bit at or after
//   ptr, wrapping modulo NREQ. Latch id, ticks and count. Go to LOAD next cycle.
//  LOAD (1 cycle): grant[id]=1, pg_rst=1. pg_ticks = latched ticks, with ticks==0
//   saturated to 1. If count==0, go to DONE; else go to RUN.
//  RUN: pg_rst=0, pg_ena=1. tick_out = pg_out. On each pg_out, remaining--.
//   When pg_out && remaining==1, go to DONE.
//   First pg_out occurs ticks-1 cycles after RUN entry (ticks=1 -> pulse every cycle).
//  DONE (1 cycle): done[id]=1, pg_rst=1, pg_ena=0. ptr = (id+1) mod NREQ.
//   Go to IDLE next cycle, with grant and busy still high for this cycle.
//  Abort: req[id] low during LOAD or RUN -> go to IDLE next cycle.
//   No done pulse; ptr = (id+1) mod NREQ.
//   If a pg_out coincides with the abort cycle, it is still forwarded on tick_out.
//  Latency: req seen in IDLE at cycle 0 -> grant at cycle 1 -> RUN from cycle 2.
//  Request inputs are sampled only in IDLE/LOAD. Changes to ticks/count mid-burst
//   are ignored.
//  A requester still high after done is treated as a new request. It re-arbitrates
//   behind the others.
//  All outputs are registered except tick_out, which is pg_out gated by (state==RUN).
// STRUCTURE
//  tick_sched_pkg: typedef enum logic [1:0] {S_IDLE,S_LOAD,S_RUN,S_DONE} sched_state_t;
//   also holds the ticks-saturation constant TICKS_MIN=1.
//  Sub-module rr_arbiter #(NREQ): inputs req, ptr; outputs one-hot gnt and index.
//   Purely combinational rotate-priority logic.
//  The top level holds the FSM, latches, remaining counter and pointer.
//  The generator is instantiated by the parent, not inside this block.
// TESTING (bench instantiates pulse_generator #(N) wired to pg_*)
//  1 req[0], ticks=4, count=3 at cycle 0 -> grant[0] at cycle 1; tick_out at cycles
//    5,9,13; done[0] at 14; busy low at 15.
//  2 req[0] and req[2] together, ticks=2, count=1, both held -> order is 0, 2, 0, 2.
//    Exactly one grant bit at any time.
//  3 ticks=0, count=5 -> pg_ticks=1; five consecutive tick_out cycles; then done.
//  4 count=0 -> LOAD then DONE; done pulses at cycle 2; pg_ena never rises.
//  5 drop req[1] mid-RUN -> IDLE next cycle, no done, pg_rst=1; next grant goes to 2.
//  6 rst=0 asynchronously mid-RUN -> grant=0, pg_ena=0, pg_rst=1 before next edge.
//    After release, state is IDLE and ptr=0.

Source files
------------

// File: rtl/tick_scheduler_pkg.sv
// Shared types and constants for the tick scheduler and its round-robin arbiter.
package tick_sched_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOAD = 2'd1,
      S_RUN  = 2'd2,
      S_DONE = 2'd3
   } sched_state_t;

   // A zero period would stall the generator; the shortest usable period is one clock.
   localparam int TICKS_MIN = 1;

endpackage

// File: rtl/tick_scheduler_rr_arbiter.sv
// Rotating-priority arbiter: picks the first asserted request at or after ptr,
// wrapping modulo NREQ. Purely combinational.
module rr_arbiter
   import tick_sched_pkg::*;
#(
   parameter int NREQ = 4,
   parameter int PW   = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [PW-1:0]   ptr,
   output logic [NREQ-1:0] gnt,
   output logic [PW-1:0]   idx,
   output logic            valid
);

   // Walk the requesters starting at ptr and keep the first one found.
   always_comb begin
      int j;
      j     = 0;
      gnt   = '0;
      idx   = '0;
      valid = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
         j = int'(ptr) + i;
         if (j >= NREQ) begin
            j = j - NREQ;
         end
         if (!valid && req[j]) begin
            valid  = 1'b1;
            idx    = PW'(j);
            gnt[j] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/tick_scheduler.sv
// Time-shares one external pulse generator among NREQ requesters. The winner's
// period is loaded into the generator, its pulses are forwarded on tick_out and
// counted, and the owner gets a one-cycle done pulse when its burst completes.
//
//  state  | meaning
//  -------+-----------------------------------------------------------------
//  S_IDLE | generator held in reset; arbitrate and latch winner's ticks/count
//  S_LOAD | grant shown, pg_ticks valid, generator still in reset (1 cycle)
//  S_RUN  | generator enabled; count its pulses down to the last one
//  S_DONE | done pulse to owner, generator back in reset (1 cycle)
module tick_scheduler
   import tick_sched_pkg::*;
#(
   parameter int NREQ = 4,
   parameter int N    = 8,
   parameter int C    = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NREQ-1:0]   req,
   input  logic [NREQ*N-1:0] req_ticks,
   input  logic [NREQ*C-1:0] req_count,
   output logic [NREQ-1:0]   grant,
   output logic [NREQ-1:0]   done,
   output logic              busy,
   output logic              tick_out,
   output logic              pg_rst,
   output logic              pg_ena,
   output logic [N-1:0]      pg_ticks,
   input  logic              pg_out
);

   localparam int PW = $clog2(NREQ);

   sched_state_t    state_q, state_d;
   logic [PW-1:0]   ptr_q, ptr_d;
   logic [PW-1:0]   id_q, id_d;
   logic [N-1:0]    ticks_q, ticks_d;
   logic [C-1:0]    remaining_q, remaining_d;

   logic [NREQ-1:0] arb_gnt;
   logic [PW-1:0]   arb_idx;
   logic            arb_valid;

   logic [N-1:0]    sel_ticks;
   logic [C-1:0]    sel_count;
   logic [PW-1:0]   next_ptr;
   logic            abort;

   logic [NREQ-1:0] own_oh;
   logic [NREQ-1:0] grant_d, done_d;
   logic            busy_d, pg_ena_d, pg_rst_d;

   rr_arbiter #(
      .NREQ (NREQ),
      .PW   (PW)
   ) u_arb (
      .req   (req),
      .ptr   (ptr_q),
      .gnt   (arb_gnt),
      .idx   (arb_idx),
      .valid (arb_valid)
   );

   assign sel_ticks = req_ticks[int'(arb_idx)*N +: N];
   assign sel_count = req_count[int'(arb_idx)*C +: C];
   assign next_ptr  = (int'(id_q) == NREQ-1) ? '0 : id_q + 1'b1;
   assign abort     = !req[id_q];

   // Next-state logic: arbitration in IDLE, abort on dropped request, pulse counting in RUN.
   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      id_d        = id_q;
      ticks_d     = ticks_q;
      remaining_d = remaining_q;
      unique case (state_q)
         S_IDLE: begin
            if (arb_valid) begin
               state_d     = S_LOAD;
               id_d        = arb_idx;
               ticks_d     = (sel_ticks == '0) ? N'(TICKS_MIN) : sel_ticks;
               remaining_d = sel_count;
            end
         end
         S_LOAD: begin
            if (abort) begin
               state_d = S_IDLE;
               ptr_d   = next_ptr;
            end else if (remaining_q == '0) begin
               state_d = S_DONE;
            end else begin
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            if (abort) begin
               state_d = S_IDLE;
               ptr_d   = next_ptr;
            end else if (pg_out) begin
               remaining_d = remaining_q - 1'b1;
               if (remaining_q == C'(1)) begin
                  state_d = S_DONE;
               end
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
            ptr_d   = next_ptr;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Owner one-hot for the cycle being entered; in IDLE the winner is not latched yet.
   always_comb begin
      own_oh = '0;
      if (state_q == S_IDLE) begin
         own_oh = arb_gnt;
      end else begin
         own_oh[id_q] = 1'b1;
      end
   end

   // Outputs are decoded from the next state so they can be registered without lag.
   always_comb begin
      busy_d   = (state_d != S_IDLE);
      pg_ena_d = (state_d == S_RUN);
      pg_rst_d = (state_d != S_RUN);
      grant_d  = busy_d ? own_oh : '0;
      done_d   = (state_d == S_DONE) ? own_oh : '0;
   end

   // FSM state, round-robin pointer and latched request fields.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= S_IDLE;
         ptr_q       <= '0;
         id_q        <= '0;
         ticks_q     <= '0;
         remaining_q <= '0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         id_q        <= id_d;
         ticks_q     <= ticks_d;
         remaining_q <= remaining_d;
      end
   end

   // Registered outputs toward the requesters and the generator.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         grant  <= '0;
         done   <= '0;
         busy   <= 1'b0;
         pg_ena <= 1'b0;
         pg_rst <= 1'b1;
      end else begin
         grant  <= grant_d;
         done   <= done_d;
         busy   <= busy_d;
         pg_ena <= pg_ena_d;
         pg_rst <= pg_rst_d;
      end
   end

   // The latched, saturated period is the generator's period; it only changes in IDLE.
   assign pg_ticks = ticks_q;

   // Only path that is not registered: a generator pulse is visible in the cycle it occurs.
   assign tick_out = pg_out & (state_q == S_RUN);

endmodule
